// File: rtl/pulser_multi.sv
// Multi-channel laser pulser: per-channel delayed warm-up/trigger windows plus a camera
// exposure window, repeating every repeat_period clocks, in continuous or burst mode.
module pulser_multi #(
  parameter int N_BITS       = 20,
  parameter int N_CH         = 2,
  parameter int N_BURST_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_BITS-1:0]        repeat_period,
  input  logic [N_BITS-1:0]        pulse_length,
  input  logic [N_BITS-1:0]        warm_up_time,
  input  logic [N_CH*N_BITS-1:0]   ch_delay,
  input  logic [N_BITS-1:0]        pre_exposure,
  input  logic [N_BITS-1:0]        exposure_time,
  input  logic [N_BURST_BITS-1:0]  burst_count,
  output logic [N_CH-1:0]          warm_up,
  output logic [N_CH-1:0]          trigger,
  output logic                     camera,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_error
);

  localparam int XW = N_BITS + 2;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_next;

  logic [N_BITS-1:0]       t;
  logic [N_BITS-1:0]       sh_p, sh_l, sh_w, sh_epre, sh_e;
  logic [N_BITS-1:0]       sh_d [N_CH];
  logic [N_BURST_BITS-1:0] burst_target, burst_done;

  logic            cfg_ok, wrap, last_burst;
  logic            load, start, fault, finish;
  logic [N_CH-1:0] win_warm, win_trig;
  logic            win_cam;
  logic [XW-1:0]   d0w_raw, cam_s, cam_e;

  // Validity of the raw input words, evaluated at every load point.
  always_comb begin
    cfg_ok = (repeat_period >= N_BITS'(2));
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (XW'(ch_delay[k*N_BITS +: N_BITS]) + XW'(warm_up_time) + XW'(pulse_length)
          > XW'(repeat_period))
        cfg_ok = 1'b0;
    end
    d0w_raw = XW'(ch_delay[N_BITS-1:0]) + XW'(warm_up_time);
    if (XW'(pre_exposure) > d0w_raw)
      cfg_ok = 1'b0;
    else if (d0w_raw - XW'(pre_exposure) + XW'(exposure_time) > XW'(repeat_period))
      cfg_ok = 1'b0;
  end

  // Window decode against the shadowed timing words.
  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      win_warm[k] = (XW'(t) >= XW'(sh_d[k])) &&
                    (XW'(t) <  XW'(sh_d[k]) + XW'(sh_w));
      win_trig[k] = (XW'(t) >= XW'(sh_d[k]) + XW'(sh_w)) &&
                    (XW'(t) <  XW'(sh_d[k]) + XW'(sh_w) + XW'(sh_l));
    end
    cam_s   = XW'(sh_d[0]) + XW'(sh_w) - XW'(sh_epre);
    cam_e   = cam_s + XW'(sh_e);
    win_cam = (XW'(t) >= cam_s) && (XW'(t) < cam_e);
  end

  assign wrap       = (t == sh_p - N_BITS'(1));
  assign last_burst = (burst_target != '0) &&
                      (burst_done + N_BURST_BITS'(1) == burst_target);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    start      = 1'b0;
    fault      = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          if (cfg_ok) begin
            state_next = RUN;
            load       = 1'b1;
            start      = 1'b1;
          end else begin
            fault = 1'b1;
          end
        end
      end
      RUN: begin
        // A burst runs to completion regardless of enable; continuous mode stops at the wrap.
        if (wrap) begin
          if (last_burst) begin
            state_next = HOLD;
            finish     = 1'b1;
          end else if (burst_target == '0 && !enable) begin
            state_next = IDLE;
          end else if (cfg_ok) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
            fault      = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      t            <= '0;
      sh_p         <= '0;
      sh_l         <= '0;
      sh_w         <= '0;
      sh_epre      <= '0;
      sh_e         <= '0;
      for (int unsigned k = 0; k < N_CH; k++) sh_d[k] <= '0;
      burst_target <= '0;
      burst_done   <= '0;
      warm_up      <= '0;
      trigger      <= '0;
      camera       <= 1'b0;
      done         <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == RUN) begin
        warm_up <= win_warm;
        trigger <= win_trig;
        camera  <= win_cam;
      end else begin
        warm_up <= '0;
        trigger <= '0;
        camera  <= 1'b0;
      end
      done <= finish;
      if (fault)      cfg_error <= 1'b1;
      else if (start) cfg_error <= 1'b0;
      if (load) begin
        sh_p    <= repeat_period;
        sh_l    <= pulse_length;
        sh_w    <= warm_up_time;
        sh_epre <= pre_exposure;
        sh_e    <= exposure_time;
        for (int unsigned k = 0; k < N_CH; k++) sh_d[k] <= ch_delay[k*N_BITS +: N_BITS];
      end
      if (start) begin
        burst_target <= burst_count;
        burst_done   <= '0;
      end else if (state == RUN && wrap) begin
        burst_done <= burst_done + N_BURST_BITS'(1);
      end
      if (state == RUN && !wrap) t <= t + N_BITS'(1);
      else                       t <= '0;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_pulser_multi.sv
// Directed bench for pulser_multi: a cycle model built from the window rules is compared
// every cycle, and literal expectations pin the model at key instants.
module tb_pulser_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [19:0] repeat_period, pulse_length, warm_up_time, pre_exposure, exposure_time;
  logic [39:0] ch_delay;
  logic [15:0] burst_count;
  logic [1:0]  warm_up, trigger;
  logic        camera, busy, done, cfg_error;

  pulser_multi #(.N_BITS(20), .N_CH(2), .N_BURST_BITS(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .repeat_period(repeat_period), .pulse_length(pulse_length),
    .warm_up_time(warm_up_time), .ch_delay(ch_delay),
    .pre_exposure(pre_exposure), .exposure_time(exposure_time),
    .burst_count(burst_count),
    .warm_up(warm_up), .trigger(trigger), .camera(camera),
    .busy(busy), .done(done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: 0 idle, 1 running, 2 holding after a burst
  int m_state = 0, m_t = 0, m_bt = 0, m_bc = 0;
  int mP = 0, mL = 0, mW = 0, mEp = 0, mE = 0;
  int mD [2] = '{0, 0};
  logic [1:0] e_warm = '0, e_trig = '0;
  logic e_cam = 1'b0, e_done = 1'b0, e_err = 1'b0;

  bit   prev_t0 = 1'b0;
  int   rises[$];
  int   done_seen = 0;

  function automatic int din(int k);
    return int'(ch_delay[k*20 +: 20]);
  endfunction

  function automatic bit inputs_valid();
    int p, w, l, ep, e;
    bit ok;
    p = int'(repeat_period); w = int'(warm_up_time); l = int'(pulse_length);
    ep = int'(pre_exposure); e = int'(exposure_time);
    ok = (p >= 2);
    for (int k = 0; k < 2; k++) if (din(k) + w + l > p) ok = 0;
    if (ep > din(0) + w) ok = 0;
    if (din(0) + w - ep + e > p) ok = 0;
    return ok;
  endfunction

  task automatic load_cfg();
    mP = int'(repeat_period); mL = int'(pulse_length); mW = int'(warm_up_time);
    mEp = int'(pre_exposure); mE = int'(exposure_time);
    for (int k = 0; k < 2; k++) mD[k] = din(k);
  endtask

  task automatic model_edge();
    int cs;
    if (reset) begin
      m_state = 0; m_t = 0; m_bt = 0; m_bc = 0;
      mP = 0; mL = 0; mW = 0; mEp = 0; mE = 0; mD[0] = 0; mD[1] = 0;
      e_warm = '0; e_trig = '0; e_cam = 0; e_done = 0; e_err = 0;
      return;
    end
    e_done = 0;
    cs = mD[0] + mW - mEp;
    for (int k = 0; k < 2; k++) begin
      e_warm[k] = (m_state == 1) && m_t >= mD[k] && m_t < mD[k] + mW;
      e_trig[k] = (m_state == 1) && m_t >= mD[k] + mW && m_t < mD[k] + mW + mL;
    end
    e_cam = (m_state == 1) && m_t >= cs && m_t < cs + mE;
    case (m_state)
      0: if (enable) begin
        if (inputs_valid()) begin
          load_cfg(); m_t = 0; m_state = 1; e_err = 0; m_bc = 0; m_bt = int'(burst_count);
        end else e_err = 1;
      end
      1: if (m_t == mP - 1) begin
        m_t = 0; m_bc++;
        if (m_bt > 0 && m_bc == m_bt) begin m_state = 2; e_done = 1; end
        else if (m_bt == 0 && !enable) m_state = 0;
        else if (inputs_valid()) load_cfg();
        else begin m_state = 0; e_err = 1; end
      end else m_t++;
      default: if (!enable) m_state = 0;
    endcase
  endtask

  task automatic step(int n);
    logic [7:0] got, exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cycle++;
      got = {warm_up, trigger, camera, busy, done, cfg_error};
      exp = {e_warm, e_trig, e_cam, m_state == 1, e_done, e_err};
      checks++;
      if (got !== exp) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model cycle %0d: {warm,trig,cam,busy,done,err} got %b expected %b",
                   cycle, got, exp);
      end
      if (trigger[0] && !prev_t0) rises.push_back(cycle);
      prev_t0 = trigger[0];
      if (done) done_seen++;
    end
  endtask

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_out(string name, int w, int tr, int c);
    chk({name, ".warm_up"}, int'(warm_up), w);
    chk({name, ".trigger"}, int'(trigger), tr);
    chk({name, ".camera"},  int'(camera),  c);
  endtask

  initial begin
    reset = 1; enable = 0;
    repeat_period = 20'd1000; pulse_length = 20'd10; warm_up_time = 20'd50;
    ch_delay = {20'd30, 20'd0}; pre_exposure = 20'd10; exposure_time = 20'd20;
    burst_count = 16'd0;
    step(2);
    reset = 0;
    step(1);
    chk_out("reset", 0, 0, 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.cfg_error", int'(cfg_error), 0);

    // Continuous run: first edge samples enable, outputs reflect t one clock later
    enable = 1;
    step(1);
    chk("start.busy", int'(busy), 1);
    chk_out("start", 0, 0, 0);
    step(1);  chk_out("t0", 1, 0, 0);
    step(30); chk_out("t30", 3, 0, 0);
    step(10); chk_out("t40", 3, 0, 1);
    step(9);  chk_out("t49", 3, 0, 1);
    step(1);  chk_out("t50", 2, 1, 1);
    step(9);  chk_out("t59", 2, 1, 1);
    step(1);  chk_out("t60", 2, 0, 0);
    step(20); chk_out("t80", 0, 2, 0);
    step(10); chk_out("t90", 0, 0, 0);
    step(910); chk_out("p2.t0", 1, 0, 0);

    // Drop enable mid-trigger: the period completes, then idle
    step(54);
    enable = 0;
    step(3);  chk_out("drop.t57", 2, 1, 1);
    step(24); chk_out("drop.t81", 0, 2, 0);
    chk("drop.busy_t81", int'(busy), 1);
    step(918);
    chk("drop.busy_wrap", int'(busy), 0);
    rises.delete();
    step(1100);
    chk("drop.no_pulses", rises.size(), 0);

    // Burst of three, hold, then a second burst on a fresh enable rise
    burst_count = 16'd3;
    done_seen = 0;
    enable = 1;
    step(1);
    rises.delete();
    step(3000);
    chk("burst.done_pulse", int'(done), 1);
    chk("burst.pulses", rises.size(), 3);
    step(200);
    chk("burst.hold_busy", int'(busy), 0);
    chk("burst.done_once", done_seen, 1);
    chk("burst.hold_pulses", rises.size(), 3);
    enable = 0;
    step(2);
    enable = 1;
    step(3001);
    chk("burst2.pulses", rises.size(), 6);
    chk("burst2.done_count", done_seen, 2);
    enable = 0; burst_count = 16'd0;
    step(2);

    // Reset while trigger[0] is high
    enable = 1;
    step(1);
    step(53); chk_out("rst.t52", 2, 1, 1);
    reset = 1;
    step(1);
    chk_out("rst.edge", 0, 0, 0);
    chk("rst.busy", int'(busy), 0);
    reset = 0;
    step(1);
    step(1); chk_out("rst.restart_t0", 1, 0, 0);
    reset = 1; enable = 0;
    step(1);
    reset = 0;
    step(2);

    // Configuration fault at start, then recovery
    ch_delay = {20'd950, 20'd0};
    enable = 1;
    step(1);
    chk("cfg.err_set", int'(cfg_error), 1);
    chk("cfg.err_busy", int'(busy), 0);
    step(20);
    chk_out("cfg.err_outputs", 0, 0, 0);
    ch_delay = {20'd30, 20'd0};
    enable = 0;
    step(1);
    enable = 1;
    step(1);
    chk("cfg.err_clear", int'(cfg_error), 0);
    chk("cfg.run_busy", int'(busy), 1);
    step(1); chk_out("cfg.t0", 1, 0, 0);

    // Fault loaded at a wrap: the current period runs, then idle with error
    ch_delay = {20'd950, 20'd0};
    step(999);
    chk("wrapfault.err", int'(cfg_error), 1);
    chk("wrapfault.busy", int'(busy), 0);
    enable = 0; ch_delay = {20'd30, 20'd0};
    step(2);

    // Period change mid-period takes effect at the next boundary
    enable = 1;
    step(1);
    rises.delete();
    step(300);
    repeat_period = 20'd500;
    step(2000);
    chk("period.count", rises.size() >= 3 ? 1 : 0, 1);
    if (rises.size() >= 3) begin
      chk("period.first_len", rises[1] - rises[0], 1000);
      chk("period.second_len", rises[2] - rises[1], 500);
    end
    enable = 0;
    step(600);
    chk("final.busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulser_multi.md
Name: pulser_multi

Overview:
- Parametrised successor to the two-channel laser pulser: N_CH independently delayed laser channels, each with a warm-up window followed by a trigger pulse, plus one camera exposure window, repeating every repeat_period clocks.
- Adds per-channel delay, a continuous or N-period burst mode, configuration shadowing, configuration error detection, and status outputs.
- Sits between the UART/register front end that supplies the timing words and the laser/camera output pins.

Parameters:
N_BITS, 20, width of all timing words (clock cycles)
N_CH, 2, number of laser channels (1..8)
N_BURST_BITS, 16, width of burst_count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request (level)
repeat_period  in  N_BITS  period length P in clocks
pulse_length  in  N_BITS  trigger high time L
warm_up_time  in  N_BITS  warm-up high time W, precedes each trigger
ch_delay  in  N_CH*N_BITS  per-channel offset D_k; channel k occupies bits [k*N_BITS +: N_BITS]
pre_exposure  in  N_BITS  camera lead E_pre before channel 0 trigger
exposure_time  in  N_BITS  camera high time E
burst_count  in  N_BURST_BITS  0 = continuous; N>0 = run N periods per enable rise
warm_up  out  N_CH  per-channel warm-up gate
trigger  out  N_CH  per-channel laser trigger
camera  out  1  camera exposure gate
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at burst completion
cfg_error  out  1  latched configuration fault

Behaviour:
- Reset: all outputs 0, state IDLE, period counter t=0, burst counter 0, shadow registers 0. Reset mid-period forces all outputs 0 on the same edge; no pulse completes.
- States: IDLE, RUN, HOLD.
- IDLE -> RUN: on the edge that samples enable=1 and a valid config. That edge latches all timing inputs into shadow registers and sets t=0.
- RUN: t increments each clock. t wraps P-1 -> 0. Shadow registers reload at every wrap, so input changes take effect only at period boundaries.
- Windows, with t against the shadowed values, half-open intervals, sums computed in N_BITS+2 bits so there is no overflow:
  - warm_up[k] = t in [D_k, D_k+W)
  - trigger[k] = t in [D_k+W, D_k+W+L)
  - camera = t in [D_0+W-E_pre, D_0+W-E_pre+E)
- Outputs are registered: each output reflects t one clock later. The first warm_up[0] with D_0=0 rises on the 2nd edge after enable is sampled.
- W=0: no warm-up, trigger starts at D_k. L=0: no trigger. E=0: no camera.
- Config is valid iff all of the following hold:
  - P >= 2
  - for every k, D_k+W+L <= P
  - E_pre <= D_0+W
  - D_0+W-E_pre+E <= P
- An invalid config at a load point (start or wrap) sets cfg_error, returns to IDLE with outputs 0, and suppresses that period. cfg_error clears on the next successful start or on reset.
- enable deasserted in RUN with continuous mode: the current period completes, then IDLE at the wrap. Pulses are never truncated; busy falls with the state change.
- Burst: the burst counter counts completed periods. At the wrap ending period N:
  - RUN -> HOLD
  - done=1 for one cycle
  - outputs 0
- HOLD -> IDLE when enable=0. A new burst needs an enable rise.
- burst_count is sampled only at start.
- Simultaneous wrap and enable=0 in burst mode: the burst ends as normal, with done asserted.
- busy=1 in RUN only.

Test Plan:
- P=1000, L=10, W=50, D={0,30}, E_pre=10, E=20, burst 0, enable at edge 0 -> relative to the first t=0 (plus 1-cycle register delay):
  - warm_up[0] high t 0..49, trigger[0] high t 50..59
  - warm_up[1] high t 30..79, trigger[1] high t 80..89
  - camera high t 40..59
  - pattern repeats every 1000 clocks.
- Same config, drop enable at t=55 -> trigger[0] still completes t 50..59, remaining windows of that period still occur, IDLE at t=999 wrap, busy falls, no further pulses.
- burst_count=3 -> exactly 3 trigger[0] pulses, done pulses once at the end of period 3, HOLD with outputs 0 until enable falls; re-raise enable -> 3 more.
- Reset asserted at t=52 (trigger[0] high) -> all outputs 0 on that edge, IDLE; deassert reset with enable high -> clean restart at t=0.
- D_1=950 with W=50, L=10 (sum 1010 > P) -> cfg_error=1, no outputs, IDLE; fix D_1=30 and re-raise enable -> cfg_error clears, normal run.
- Change P to 500 mid-period -> current period still 1000 clocks, next period 500 clocks.
